// File: rtl/ciphertext_byte_streamer.sv
// rtl/ciphertext_byte_streamer.sv - buffers 128-bit ciphertext blocks and streams them out as bytes
//
// Purpose:
//   Accepts whole 128-bit ciphertext blocks from the final-round stage into a small
//   block FIFO and serialises the head block as 16 bytes over a valid/ready byte
//   interface, byte 0 first. Optional completed-block counter under the
//   CT_STREAMER_STATS_EN macro.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort of all buffered and partial blocks
//   ct_valid     block valid from final-round stage
//   ct_ready     registered: a block can be accepted this cycle
//   ciphertext   [0:127] block, byte k = ciphertext[8k:8k+7]
//   out_valid    out_data holds a valid byte
//   out_ready    downstream accepts the byte
//   out_data     current byte, out_data[7] = ciphertext bit 8k
//   out_last     high with byte 15 of each block
//   blocks_sent  completed-block counter (CT_STREAMER_STATS_EN only)

module ciphertext_byte_streamer #(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [0:127] ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last
`ifdef CT_STREAMER_STATS_EN
  ,
  output logic [31:0]  blocks_sent
`endif
);

  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic             ct_ready_q, ct_ready_d;

  // Block storage; deliberately not reset, its contents are only visible via out_valid.
  logic [0:127] mem_q [FIFO_DEPTH];

  logic push;
  logic pop_byte;
  logic pop_block;

  assign push      = ct_valid & ct_ready_q;
  assign pop_byte  = out_valid & out_ready;
  assign pop_block = pop_byte & (byte_idx_q == 4'd15);

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    if (flush) begin
      // Flush wins over any push or pop presented on the same edge.
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_idx_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_byte) begin
        // 4-bit index wraps 15 -> 0 on the final byte.
        byte_idx_d = byte_idx_q + 1'b1;
      end
      if (pop_block) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_block);
    end
    // Looks at the post-edge occupancy so ct_ready never depends on out_ready combinationally.
    ct_ready_d = (count_d < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      ct_ready_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      ct_ready_q <= ct_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= ciphertext;
    end
  end

  assign ct_ready  = ct_ready_q;
  assign out_valid = (count_q != '0);
  assign out_last  = (byte_idx_q == 4'd15);
  // Gated so the unreset storage never leaks onto out_data while the FIFO is empty.
  assign out_data  = out_valid ? mem_q[rd_ptr_q][{byte_idx_q, 3'b000} +: 8] : 8'h00;

`ifdef CT_STREAMER_STATS_EN
  logic [31:0] blocks_sent_q, blocks_sent_d;

  always_comb begin
    blocks_sent_d = blocks_sent_q;
    if (pop_block && !flush) begin
      blocks_sent_d = blocks_sent_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocks_sent_q <= '0;
    end else begin
      blocks_sent_q <= blocks_sent_d;
    end
  end

  assign blocks_sent = blocks_sent_q;
`endif

endmodule

// File: tb/tb_ciphertext_byte_streamer.sv
// tb/tb_ciphertext_byte_streamer.sv - randomized self-checking bench for ciphertext_byte_streamer

module tb_ciphertext_byte_streamer;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         ct_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] ciphertext = '0;
  logic         ct_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
`ifdef CT_STREAMER_STATS_EN
  logic [31:0]  blocks_sent;
`endif

  ciphertext_byte_streamer #(.FIFO_DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .ciphertext (ciphertext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef CT_STREAMER_STATS_EN
    ,
    .blocks_sent(blocks_sent)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of whole blocks plus the position inside the head block.
  logic [127:0] m_fifo[$];
  int           m_idx;
  logic         m_ready;
  logic [31:0]  m_sent;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_byte();
    logic [127:0] h;
    if (m_fifo.size() == 0) return 8'h00;
    h = m_fifo[0];
    return h[127 - 8*m_idx -: 8];
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_idx   = 0;
    m_ready = 1'b0;
    m_sent  = '0;
  endtask

  task automatic model_edge(input logic v, input logic r, input logic f, input logic [127:0] d);
    logic push;
    push = v && m_ready;
    if (f) begin
      m_fifo.delete();
      m_idx = 0;
    end else begin
      if (m_fifo.size() != 0 && r) begin
        if (m_idx == 15) begin
          void'(m_fifo.pop_front());
          m_idx  = 0;
          m_sent = m_sent + 1;
        end else begin
          m_idx++;
        end
      end
      if (push) m_fifo.push_back(d);
    end
    m_ready = (m_fifo.size() < DEPTH);
  endtask

  task automatic check_outputs(input string where);
    expect_eq({where, ".out_valid"}, 32'(out_valid), 32'(m_fifo.size() != 0));
    expect_eq({where, ".out_data"},  32'(out_data),  32'(m_byte()));
    expect_eq({where, ".out_last"},  32'(out_last),  32'(m_idx == 15));
    expect_eq({where, ".ct_ready"},  32'(ct_ready),  32'(m_ready));
`ifdef CT_STREAMER_STATS_EN
    expect_eq({where, ".blocks_sent"}, blocks_sent, m_sent);
`endif
  endtask

  // One clock: drive inputs away from the edge, advance the model at the edge, check after.
  task automatic step(input string where, input logic v, input logic r, input logic f,
                      input logic [127:0] d);
    ct_valid   = v;
    out_ready  = r;
    flush      = f;
    ciphertext = d;
    @(posedge clk);
    model_edge(v, r, f, d);
    #1;
    check_outputs(where);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] blk;
    model_reset();
    #3;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step("first_edge", 1'b0, 1'b0, 1'b0, '0);

    // Single block with out_ready held high.
    step("t1_push", 1'b1, 1'b1, 1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    expect_eq("t1_byte0", 32'(out_data), 32'h00);
    for (int i = 0; i < 18; i++) step("t1_stream", 1'b0, 1'b1, 1'b0, '0);

    // Three back-to-back pushes against a stalled consumer, then drain.
    for (int i = 0; i < 3; i++) step("t2_fill", 1'b1, 1'b0, 1'b0, rand_block());
    expect_eq("t2_full_ready", 32'(ct_ready), 32'(0));
    for (int i = 0; i < 60; i++) step("t2_drain", 1'b1, 1'b1, 1'b0, rand_block());
    for (int i = 0; i < 40; i++) step("t2_empty", 1'b0, 1'b1, 1'b0, '0);

    // Alternating out_ready.
    blk = 128'h00010203_04050607_08090A0B_0C0D0E0F;
    step("t3_push", 1'b1, 1'b0, 1'b0, blk);
    for (int i = 0; i < 36; i++) step("t3_toggle", 1'b0, 1'(i % 2), 1'b0, '0);

    // Flush mid-block with another block queued and ct_valid on the same edge.
    step("t4_pushA", 1'b1, 1'b1, 1'b0, rand_block());
    step("t4_pushB", 1'b1, 1'b1, 1'b0, rand_block());
    for (int i = 0; i < 20 && m_idx != 7; i++) step("t4_adv", 1'b0, 1'b1, 1'b0, '0);
    expect_eq("t4_at_idx7", 32'(m_idx), 32'd7);
    step("t4_flush", 1'b1, 1'b1, 1'b1, rand_block());
    expect_eq("t4_flushed_valid", 32'(out_valid), 32'(0));
    for (int i = 0; i < 3; i++) step("t4_idle", 1'b0, 1'b1, 1'b0, '0);
    step("t4_pushD", 1'b1, 1'b1, 1'b0, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
    expect_eq("t4_restart_byte0", 32'(out_data), 32'hA0);
    for (int i = 0; i < 18; i++) step("t4_drain", 1'b0, 1'b1, 1'b0, '0);

    // Async reset mid-block, then one full block afterwards.
    step("t5_push", 1'b1, 1'b1, 1'b0, rand_block());
    for (int i = 0; i < 5; i++) step("t5_adv", 1'b0, 1'b1, 1'b0, '0);
    async_reset();
    step("t5_first_edge", 1'b0, 1'b1, 1'b0, '0);
    step("t5_push2", 1'b1, 1'b1, 1'b0, rand_block());
    for (int i = 0; i < 18; i++) step("t5_drain", 1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic with varying consumer speed and rare flushes.
    for (int i = 0; i < 4000; i++) begin
      int mode;
      logic r;
      mode = (i / 500) % 4;
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) == 0);
        2:       r = ($urandom_range(0, 1) == 0);
        default: r = ($urandom_range(0, 7) != 0);
      endcase
      step("rand", ($urandom_range(0, 3) != 0), r, ($urandom_range(0, 99) == 0), rand_block());
      if (i == 2222) begin
        async_reset();
        step("rand_rst_edge", 1'b0, 1'b0, 1'b0, '0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
